// File: rtl/output_readout_streamer_if.sv
// Output word stream of the readout streamer: valid/ready handshake with last flag.
interface output_readout_streamer_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/output_readout_streamer.sv
// output_readout_streamer: reads LEN consecutive words from a registered-read
// result memory starting at BASE and streams them with a last flag.
// Optional feature macro: READOUT_RELU_EN (clamp negative words to zero before the FIFO).
module output_readout_streamer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output_readout_streamer_if.master m
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 4) + 1;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_done_nxt;

  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_issued;
  logic [ADDR_W:0]     w_issued_inc;
  logic [ADDR_W:0]     w_len_eff;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_done;

  // Read pipeline: address register stage, then memory data register stage.
  logic                r_a_vld, r_a_last;
  logic                r_d_vld, r_d_last;

  // FIFO storage plus registered output head.
  logic [DATA_W-1:0]   r_q      [FIFO_DEPTH];
  logic                r_q_last [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0]    r_qcnt;
  logic                r_o_vld;
  logic [DATA_W-1:0]   r_o_data;
  logic                r_o_last;

  logic                w_accept;
  logic                w_issue_run;
  logic                w_pop;
  logic                w_push;
  logic                w_load;
  logic                w_credit;
  logic                w_last_pop;
  logic [OCC_W-1:0]    w_occ;
  logic [DATA_W-1:0]   w_push_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_len_eff    = (length > LEN_MAX) ? LEN_MAX : length;
  assign w_issued_inc = r_issued + 1'b1;
  assign w_accept     = (r_state == S_IDLE) && start && (length != '0);
  assign w_pop        = r_o_vld && m.ready;
  assign w_push       = r_d_vld;
  assign w_load       = (r_qcnt != '0) && (!r_o_vld || w_pop);
  assign w_last_pop   = w_pop && r_o_last;

  // The output head register is counted as a FIFO entry, so the credit covers
  // queued words, the head, and both read pipeline stages.
  assign w_occ    = OCC_W'(r_qcnt) + OCC_W'(r_o_vld) + OCC_W'(r_a_vld) + OCC_W'(r_d_vld);
  assign w_credit = (w_occ - OCC_W'(w_pop)) < OCC_W'(FIFO_DEPTH);
  assign w_issue_run = (r_state == S_RUN) && (r_issued < r_len) && w_credit;

`ifdef READOUT_RELU_EN
  assign w_push_data = mem_data[DATA_W-1] ? '0 : mem_data;
`else
  assign w_push_data = mem_data;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and done-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if ((r_issued == r_len) || (w_issue_run && (w_issued_inc == r_len)))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_pop && (r_qcnt == '0) && !r_a_vld && !r_d_vld) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read issue, pipeline flags, FIFO control and output head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= '0;
      r_issued   <= '0;
      r_mem_addr <= '0;
      r_a_vld    <= 1'b0;
      r_a_last   <= 1'b0;
      r_d_vld    <= 1'b0;
      r_d_last   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_qcnt     <= '0;
      r_o_vld    <= 1'b0;
      r_o_data   <= '0;
      r_o_last   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;

      if (w_accept) begin
        r_len      <= w_len_eff;
        r_issued   <= LEN_ONE;
        r_mem_addr <= base_addr;
        r_a_vld    <= 1'b1;
        r_a_last   <= (w_len_eff == LEN_ONE);
      end else if (w_issue_run) begin
        r_issued   <= w_issued_inc;
        r_mem_addr <= r_mem_addr + 1'b1;
        r_a_vld    <= 1'b1;
        r_a_last   <= (w_issued_inc == r_len);
      end else begin
        r_a_vld    <= 1'b0;
        r_a_last   <= 1'b0;
      end

      r_d_vld  <= r_a_vld;
      r_d_last <= r_a_last;

      if (w_push) r_wptr <= ptr_inc(r_wptr);

      if (w_load) begin
        r_rptr   <= ptr_inc(r_rptr);
        r_o_vld  <= 1'b1;
        r_o_data <= r_q[r_rptr];
        r_o_last <= r_q_last[r_rptr];
      end else if (w_pop) begin
        r_o_vld  <= 1'b0;
      end

      unique case ({w_push, w_load})
        2'b10:   r_qcnt <= r_qcnt + 1'b1;
        2'b01:   r_qcnt <= r_qcnt - 1'b1;
        default: r_qcnt <= r_qcnt;
      endcase
    end
  end

  // FIFO storage write; contents are qualified by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_wptr]      <= w_push_data;
      r_q_last[r_wptr] <= r_d_last;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign mem_addr = r_mem_addr;
  assign m.valid  = r_o_vld;
  assign m.data   = r_o_data;
  assign m.last   = r_o_last;

endmodule
